// File: rtl/shift_reg_if.sv
// Stream-side bundle for the Huffman front-end bit accumulator.
// SHIFT_REG_STATUS_EN adds the empty/full/load_drop status flags.
interface shift_reg_if #(
    parameter int MAX_CODE = 9
);
    logic                load_bits;
    logic [3:0]          in_bits;
    logic [2:0]          in_len;
    logic                shift_en;
    logic [3:0]          shift_len;
    logic [MAX_CODE-1:0] shift_buf;
    logic [3:0]          bit_count;
`ifdef SHIFT_REG_STATUS_EN
    logic                empty;
    logic                full;
    logic                load_drop;

    modport master (
        output load_bits, in_bits, in_len, shift_en, shift_len,
        input  shift_buf, bit_count, empty, full, load_drop
    );
    modport slave (
        input  load_bits, in_bits, in_len, shift_en, shift_len,
        output shift_buf, bit_count, empty, full, load_drop
    );
`else
    modport master (
        output load_bits, in_bits, in_len, shift_en, shift_len,
        input  shift_buf, bit_count
    );
    modport slave (
        input  load_bits, in_bits, in_len, shift_en, shift_len,
        output shift_buf, bit_count
    );
`endif
endinterface

// File: rtl/shift_reg.sv
// Bit accumulator: appends up to 4 stream bits per cycle, consumes matched code bits.
// Optional status flags (empty/full/load_drop) under SHIFT_REG_STATUS_EN.
module shift_reg #(
    parameter int MAX_CODE = 9
) (
    input  logic        clk,
    input  logic        reset,
    shift_reg_if.slave  bus
);
    logic [MAX_CODE-1:0] data_q, sh_buf, nxt_buf, ins;
    logic [3:0]          cnt_q, sh_cnt, nxt_cnt;
    logic [3:0]          in_mask;
    logic [4:0]          sum;
    logic                accept, drop;

    always_comb begin
        sh_buf  = data_q;
        sh_cnt  = cnt_q;
        // Consume first; asking for more than is held flushes the window.
        if (bus.shift_en && bus.shift_len != 4'd0) begin
            if (bus.shift_len > cnt_q) begin
                sh_buf = '0;
                sh_cnt = 4'd0;
            end else begin
                sh_buf = data_q >> bus.shift_len;
                sh_cnt = cnt_q - bus.shift_len;
            end
        end

        for (int i = 0; i < 4; i++)
            in_mask[i] = bus.in_bits[i] & (i < int'(bus.in_len));

        sum    = {1'b0, sh_cnt} + {2'b00, bus.in_len};
        accept = bus.load_bits && (bus.in_len <= 3'd4) && (sum <= 5'(MAX_CODE));
        drop   = bus.load_bits && !accept;
        ins    = MAX_CODE'(in_mask) << sh_cnt;

        nxt_buf = sh_buf;
        nxt_cnt = sh_cnt;
        if (accept) begin
            nxt_buf = sh_buf | ins;
            nxt_cnt = sum[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            cnt_q  <= 4'd0;
        end else begin
            data_q <= nxt_buf;
            cnt_q  <= nxt_cnt;
        end
    end

    assign bus.shift_buf = data_q;
    assign bus.bit_count = cnt_q;

`ifdef SHIFT_REG_STATUS_EN
    logic empty_q, full_q, drop_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            empty_q <= (nxt_cnt == 4'd0);
            full_q  <= (nxt_cnt == 4'(MAX_CODE));
            drop_q  <= drop;
        end
    end

    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.load_drop = drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_shift_reg.sv
// Directed-vector bench for shift_reg (MAX_CODE=9); status flags checked when
// SHIFT_REG_STATUS_EN is defined.
module tb_shift_reg;
    localparam int MC = 9;

    typedef struct {
        logic       rst_n;
        logic       load;
        logic [3:0] bits;
        logic [2:0] len;
        logic       sh;
        logic [3:0] sh_len;
        logic [8:0] exp_buf;
        logic [3:0] exp_cnt;
        logic       exp_drop;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    shift_reg_if #(.MAX_CODE(MC)) bus ();
    shift_reg #(.MAX_CODE(MC)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic ld, input logic [3:0] b, input logic [2:0] l,
                       input logic s, input logic [3:0] sl, input logic [8:0] eb,
                       input logic [3:0] ec, input logic ed, input string nm);
        vec_t v;
        v.rst_n = r; v.load = ld; v.bits = b; v.len = l; v.sh = s; v.sh_len = sl;
        v.exp_buf = eb; v.exp_cnt = ec; v.exp_drop = ed; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic ld, input logic [3:0] b, input logic [2:0] l,
                         input logic s, input logic [3:0] sl);
        @(negedge clk);
        reset = r; bus.load_bits = ld; bus.in_bits = b; bus.in_len = l;
        bus.shift_en = s; bus.shift_len = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [8:0] eb, input logic [3:0] ec,
                         input logic ed);
        n_tests++;
        if (bus.shift_buf !== eb) begin
            n_fail++;
            $display("FAIL %s buf: got %b want %b", nm, bus.shift_buf, eb);
        end
        n_tests++;
        if (bus.bit_count !== ec) begin
            n_fail++;
            $display("FAIL %s count: got %0d want %0d", nm, bus.bit_count, ec);
        end
`ifdef SHIFT_REG_STATUS_EN
        n_tests++;
        if (bus.empty !== (ec == 4'd0) || bus.full !== (ec == 4'(MC)) || bus.load_drop !== ed) begin
            n_fail++;
            $display("FAIL %s flags: got e%b f%b d%b want e%b f%b d%b", nm, bus.empty, bus.full,
                     bus.load_drop, (ec == 4'd0), (ec == 4'(MC)), ed);
        end
`else
        if (ed === 1'bx) $display("bad vector %s", nm);
`endif
    endtask

    initial begin
        reset = 1'b0; bus.load_bits = 1'b0; bus.in_bits = 4'd0; bus.in_len = 3'd0;
        bus.shift_en = 1'b0; bus.shift_len = 4'd0;

        // reset held two cycles while a load is driven, then idle after release
        drive(1'b0, 1'b1, 4'b1111, 3'd4, 1'b0, 4'd0);
        check("rst_c1", 9'h000, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 4'b1111, 3'd4, 1'b0, 4'd0);
        check("rst_c2", 9'h000, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 4'b1111, 3'd4, 1'b0, 4'd0);
        check("rst_rel", 9'h000, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 4'd0);
        check("idle", 9'h000, 4'd0, 1'b0);

        //  rst   ld    bits     len   sh    sh_len  exp_buf       cnt   drop
        add(1'b1, 1'b1, 4'b0111, 3'd4, 1'b0, 4'd0, 9'b000000111, 4'd4, 1'b0, "p2_ld1");
        add(1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 4'd1, 9'b000000011, 4'd3, 1'b0, "p2_sh1");
        add(1'b1, 1'b1, 4'b0110, 3'd4, 1'b0, 4'd0, 9'b000110011, 4'd7, 1'b0, "p2_ld2");
        add(1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 4'd4, 9'b000000011, 4'd3, 1'b0, "p2_sh4");
        add(1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 4'd3, 9'b000000000, 4'd0, 1'b0, "sh_exact");
        add(1'b1, 1'b1, 4'b1111, 3'd4, 1'b0, 4'd0, 9'b000001111, 4'd4, 1'b0, "p3_ld1");
        add(1'b1, 1'b1, 4'b0101, 3'd4, 1'b0, 4'd0, 9'b001011111, 4'd8, 1'b0, "p3_ld2");
        add(1'b1, 1'b1, 4'b0001, 3'd1, 1'b0, 4'd0, 9'b101011111, 4'd9, 1'b0, "p3_full");
        add(1'b1, 1'b1, 4'b1010, 3'd4, 1'b0, 4'd0, 9'b101011111, 4'd9, 1'b1, "p3_ovf");
        add(1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 4'd0, 9'b101011111, 4'd9, 1'b0, "sh_zero");
        add(1'b1, 1'b1, 4'b1010, 3'd4, 1'b1, 4'd1, 9'b010101111, 4'd8, 1'b1, "sh_ld_ovf");
        add(1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 4'd9, 9'b000000000, 4'd0, 1'b0, "p3_over");
        add(1'b1, 1'b1, 4'b1011, 3'd3, 1'b0, 4'd0, 9'b000000011, 4'd3, 1'b0, "mask_ld");
        add(1'b1, 1'b1, 4'b1111, 3'd2, 1'b1, 4'd2, 9'b000000110, 4'd3, 1'b0, "p4_both");
        add(1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 4'd0, 9'b000000110, 4'd3, 1'b0, "len0");
        add(1'b1, 1'b0, 4'b0000, 3'd0, 1'b1, 4'd6, 9'b000000000, 4'd0, 1'b0, "p5_over");
        add(1'b1, 1'b1, 4'b1111, 3'd5, 1'b0, 4'd0, 9'b000000000, 4'd0, 1'b1, "p5_len5");
        add(1'b1, 1'b1, 4'b1111, 3'd4, 1'b0, 4'd0, 9'b000001111, 4'd4, 1'b0, "p6_ld1");
        add(1'b1, 1'b1, 4'b1101, 3'd3, 1'b0, 4'd0, 9'b001011111, 4'd7, 1'b0, "p6_ld2");
        add(1'b0, 1'b0, 4'b0000, 3'd0, 1'b1, 4'd2, 9'b000000000, 4'd0, 1'b0, "p6_rst");
        add(1'b1, 1'b1, 4'b0001, 3'd1, 1'b0, 4'd0, 9'b000000001, 4'd1, 1'b0, "p6_ld3");

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].load, vecs[i].bits, vecs[i].len, vecs[i].sh, vecs[i].sh_len);
            check(vecs[i].name, vecs[i].exp_buf, vecs[i].exp_cnt, vecs[i].exp_drop);
        end

        // drop flag is a single-cycle pulse; state holds when idle
        drive(1'b1, 1'b1, 4'b1111, 3'd7, 1'b0, 4'd0);
        check("len7", 9'b000000001, 4'd1, 1'b1);
        drive(1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 4'd0);
        check("drop_clr", 9'b000000001, 4'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_reg.md
Name: shift_reg

Overview:
Bit-accumulator buffer for the Huffman decoder front end. It collects variable-length chunks of at most 4 bits from the input stream into a MAX_CODE-bit window. It then releases consumed code bits once the decoder has matched a codeword of length shift_len. The oldest stream bit is always at shift_buf[0].

Parameters:
MAX_CODE, 9, buffer width in bits and the longest codeword length; legal range 4..15 because bit_count is 4 bits wide.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-low reset; buffer clears on the rising clk edge when reset==0.
load_bits  input  1  append request for this cycle.
in_bits  input  4  new stream bits; in_bits[0] is the earliest bit.
in_len  input  3  number of valid bits in in_bits; legal values 0..4.
shift_en  input  1  consume request for this cycle.
shift_len  input  4  number of bits to consume from the bottom of the buffer.
shift_buf  output  MAX_CODE  buffer contents; valid bits are [bit_count-1:0].
bit_count  output  4  number of valid bits held, 0..MAX_CODE.

Behaviour:
- Reset (reset==0 at a clk edge): shift_buf=0 and bit_count=0. Reset overrides load_bits and shift_en.
- Outputs are registered; an operation is visible one cycle after the edge that samples it.
- Invariant: all shift_buf bits at or above bit_count are 0.
- Shift step, when shift_en==1:
  - shift_len <= bit_count: shift_buf = shift_buf >> shift_len and bit_count -= shift_len.
  - shift_len > bit_count (over-consume): shift_buf=0 and bit_count=0.
  - shift_len==0: no-op.
- Load step, when load_bits==1, evaluated on the post-shift count c:
  - Accept only if in_len<=4 and c+in_len<=MAX_CODE.
  - On accept: shift_buf |= (in_bits masked to its low in_len bits) << c, and bit_count = c+in_len.
  - Otherwise (overflow, or in_len 5..7): the load is dropped and the buffer keeps its post-shift state.
  - in_len==0: no-op.
- Simultaneous shift and load in one cycle: shift first, then append. Result lands in the same edge.
- Bits of in_bits above in_len are ignored.
- No other state and no handshake; the upstream block must check bit_count before loading.

Optional Feature:
SHIFT_REG_STATUS_EN
- When defined, three extra registered outputs are present:
  - empty (1): 1 when bit_count==0.
  - full (1): 1 when bit_count==MAX_CODE.
  - load_drop (1): a one-cycle pulse the cycle after a load_bits request is rejected.
- All three flags are reset-consistent: empty=1, full=0, load_drop=0 at reset.
- When not defined, these ports do not exist and the core behaviour is unchanged.

Test Plan:
1. Reset held low 2 cycles, with load_bits=1, in_bits=1111, in_len=4 driven -> shift_buf=0, bit_count=0. Release reset -> state stays 0/0 until the first load.
2. Load 0111 len 4 -> buf=000000111, count 4. Shift 1 -> 000000011, count 3. Load 0110 len 4 -> 000110011, count 7. Shift 4 -> 000000011, count 3.
3. From empty:
   - Load 1111/4 -> buf=000001111, count 4.
   - Load 0101/4 -> buf=001011111, count 8.
   - Load 0001/1 -> buf=101011111, count 9.
   - Load 1010/4 -> unchanged at 101011111, count 9 (load_drop pulses if enabled).
   - Shift 9 -> buf 0, count 0.
4. With buf=000000011 and count 3, apply shift_en len 2 and load 1111 len 2 in the same cycle -> buf=000000110, count 3.
5. With count 3, shift 6 -> buf=0, count 0. Then load in_len=5 -> ignored, count stays 0.
6. Mid-stream with count 7, drive reset=0 for one edge while shift_en=1 -> buf=0, count 0. The next load 0001/1 -> buf=000000001, count 1.
